// File: rtl/cell_alu_pkg.sv
// Shared types and constants for the multi-cycle cell-core ALU.
// Opcode encodings, FSM states, saturation bounds and divider iteration counts.
package cell_alu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    DIVIDE = 1'b1
  } state_e;

  localparam logic [3:0] OP_LI   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SEQ  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_FMUL = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_FDIV = 4'd12;

  // Largest positive value of an rl-bit signed word, as a bit pattern.
  function automatic logic [127:0] sat_max(input int rl);
    return (128'd1 << (rl - 1)) - 128'd1;
  endfunction

  // Most negative value of an rl-bit signed word, as a bit pattern.
  function automatic logic [127:0] sat_min(input int rl);
    return 128'd1 << (rl - 1);
  endfunction

  // Quotient bits produced for integer division.
  function automatic int iter_div(input int rl);
    return rl;
  endfunction

  // Quotient bits produced for fixed-point division.
  function automatic int iter_fdiv(input int rl, input int frac);
    return rl + frac;
  endfunction

endpackage

// File: rtl/cell_core_divider.sv
// Iterative signed divider: restoring division on magnitudes, one bit per cycle.
// done_o pulses in the cycle whose closing edge writes the last quotient bit.
module cell_core_divider
  import cell_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             fdiv_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int W  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] IT_DIV  = CW'(iter_div(WIDTH));
  localparam logic [CW-1:0] IT_FDIV =
    CW'(iter_fdiv(WIDTH, FRAC_BITS));
  localparam logic [CW-1:0] ONE = CW'(1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [W-1:0]     quo_n;

  assign abs_a = a_i[WIDTH-1] ? -a_i : a_i;
  assign abs_b = b_i[WIDTH-1] ? -b_i : b_i;

  // The remainder never exceeds the divisor, so WIDTH bits plus the
  // shifted-in carry are enough for the trial subtraction.
  assign trial = {rem_q, quo_q[W-1]};
  assign ge    = trial[WIDTH] | (trial[WIDTH-1:0] >= dvs_q);
  assign rem_n = ge ? trial[WIDTH-1:0] - dvs_q : trial[WIDTH-1:0];
  assign quo_n = {quo_q[W-2:0], ge};

  assign busy_o = busy_q;
  assign done_o = busy_q & (cnt_q == ONE);

`ifdef CELL_ALU_SATURATE_EN
  localparam logic [W-1:0] LIM_POS = W'(sat_max(WIDTH));
  localparam logic [W-1:0] LIM_NEG = W'(sat_min(WIDTH));
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  // Clamp the signed quotient into the result range.
  always_comb begin
    quotient_o = neg_q ? -quo_n[WIDTH-1:0] : quo_n[WIDTH-1:0];
    if (!neg_q && (quo_n > LIM_POS)) quotient_o = SMAX;
    if (neg_q && (quo_n > LIM_NEG))  quotient_o = SMIN;
  end
`else
  // Apply the sign and keep the low WIDTH bits.
  always_comb begin
    quotient_o = neg_q ? -quo_n[WIDTH-1:0] : quo_n[WIDTH-1:0];
  end
`endif

  // Load operands on start, then shift in one quotient bit per cycle.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    neg_d  = neg_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = fdiv_i ? IT_FDIV : IT_DIV;
      rem_d  = '0;
      quo_d  = W'(abs_a) << FRAC_BITS;
      dvs_d  = abs_b;
      neg_d  = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end else if (busy_q) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q - ONE;
      if (cnt_q == ONE) busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      neg_q  <= neg_d;
    end
  end

endmodule

// File: rtl/cell_core_alu_mc.sv
// Multi-cycle cell-core ALU with valid/ready handshake and iterative DIV/FDIV.
// CELL_ALU_SATURATE_EN selects clamping instead of wrapping for arithmetic ops.
module cell_core_alu_mc
  import cell_alu_pkg::*;
#(
  parameter int REGISTER_LENGTH = 32,
  parameter int FRAC_BITS       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 opcode,
  input  logic [7:0]                 immediate,
  input  logic [REGISTER_LENGTH-1:0] first_operand,
  input  logic [REGISTER_LENGTH-1:0] second_operand,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REGISTER_LENGTH-1:0] result,
  output logic                       div_by_zero
);

  localparam int RL = REGISTER_LENGTH;
  localparam int PW = 2 * RL;
  localparam logic [RL-1:0] SMAX = RL'(sat_max(RL));
  localparam logic [RL-1:0] SMIN = RL'(sat_min(RL));
  localparam logic [RL-1:0] RL_U = RL'(RL);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [RL-1:0]   result_q, result_d;
  logic            dbz_q, dbz_d;

  logic            accept, is_div, b_zero;
  logic            div_start, div_busy, div_done;
  logic [RL-1:0]   div_quo;
  logic [RL-1:0]   a, b;
  logic signed [RL-1:0] a_s, b_s;
  logic signed [PW-1:0] prod_w;
  logic [RL-1:0]   add_r, sub_r, mul_r, fmul_r;
  logic [RL-1:0]   diff, shr_r, alu_res;

  assign a   = first_operand;
  assign b   = second_operand;
  assign a_s = first_operand;
  assign b_s = second_operand;

  assign in_ready  = (state_q == IDLE) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_div    = (opcode == OP_DIV) | (opcode == OP_FDIV);
  assign b_zero    = (b == '0);
  assign div_start = accept & is_div & ~b_zero;

  assign prod_w = PW'(a_s) * PW'(b_s);
  assign diff   = a - b;
  assign shr_r  = (b >= RL_U) ? {RL{a[RL-1]}} : RL'(a_s >>> b);

`ifdef CELL_ALU_SATURATE_EN
  logic [RL:0] add_w, sub_w;
  logic        mul_fit, fmul_fit;

  assign add_w = {a[RL-1], a} + {b[RL-1], b};
  assign sub_w = {a[RL-1], a} - {b[RL-1], b};
  assign mul_fit  = (&prod_w[PW-1:RL-1]) | ~(|prod_w[PW-1:RL-1]);
  assign fmul_fit = (&prod_w[PW-1:RL+FRAC_BITS-1]) |
                    ~(|prod_w[PW-1:RL+FRAC_BITS-1]);

  assign add_r = (add_w[RL] != add_w[RL-1]) ?
                 (add_w[RL] ? SMIN : SMAX) : add_w[RL-1:0];
  assign sub_r = (sub_w[RL] != sub_w[RL-1]) ?
                 (sub_w[RL] ? SMIN : SMAX) : sub_w[RL-1:0];
  assign mul_r = mul_fit ? prod_w[RL-1:0] :
                 (prod_w[PW-1] ? SMIN : SMAX);
  assign fmul_r = fmul_fit ? prod_w[RL+FRAC_BITS-1:FRAC_BITS] :
                  (prod_w[PW-1] ? SMIN : SMAX);
`else
  logic unused_prod;

  assign add_r  = a + b;
  assign sub_r  = a - b;
  assign mul_r  = prod_w[RL-1:0];
  assign fmul_r = prod_w[RL+FRAC_BITS-1:FRAC_BITS];
  assign unused_prod = ^prod_w[PW-1:RL+FRAC_BITS];
`endif

  cell_core_divider #(
    .WIDTH     (RL),
    .FRAC_BITS (FRAC_BITS)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .fdiv_i     (opcode == OP_FDIV),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // Single-cycle result; DIV/FDIV here only covers the zero divisor.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_LI:   alu_res = RL'($signed(immediate));
      OP_ADD:  alu_res = add_r;
      OP_SUB:  alu_res = sub_r;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SEQ:  alu_res = RL'(a == b);
      OP_SLT:  alu_res = RL'(diff[RL-1]);
      OP_MUL:  alu_res = mul_r;
      OP_SHR:  alu_res = shr_r;
      OP_FMUL: alu_res = fmul_r;
      OP_DIV,
      OP_FDIV: alu_res = a[RL-1] ? SMIN : SMAX;
      default: alu_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: stay in DIVIDE until the last quotient bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (div_start) state_d = DIVIDE;
      DIVIDE: if (div_done || !div_busy) state_d = IDLE;
    endcase
  end

  // Output register next values: a new result wins over consumption.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && !div_start) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      dbz_d       = is_div;
    end else if (state_q == DIVIDE && div_done) begin
      out_valid_d = 1'b1;
      result_d    = div_quo;
      dbz_d       = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
